// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: sequencer for an in-place radix-2 DIT FFT with a single
// combinational butterfly. It walks every stage, issuing one butterfly per
// cycle (read pair, twiddle index), then echoes the read pair one cycle later
// as the write pair. A one-cycle gap separates stages so that a stage never
// reads a location that the previous stage is still writing.
module fft_stage_ctrl #(
  parameter int LOG2_N = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [LOG2_N-1:0] o_stage,
  output logic              o_rd_en,
  output logic [LOG2_N-1:0] o_rd_addr_A,
  output logic [LOG2_N-1:0] o_rd_addr_B,
  output logic [LOG2_N-2:0] o_tw_addr,
  output logic              o_wr_en,
  output logic [LOG2_N-1:0] o_wr_addr_A,
  output logic [LOG2_N-1:0] o_wr_addr_B
);

  localparam int N   = 1 << LOG2_N;
  localparam int BFW = LOG2_N - 1;
  localparam logic [BFW-1:0]    BF_LAST    = BFW'(N / 2 - 1);
  localparam logic [LOG2_N-1:0] STAGE_LAST = LOG2_N'(LOG2_N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [LOG2_N-1:0] stage_reg, stage_next;
  logic [BFW-1:0]    bf_reg, bf_next;

  // Next-state logic: stage and butterfly counters advance with the FSM.
  always_comb begin
    state_next = state_reg;
    stage_next = stage_reg;
    bf_next    = bf_reg;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          state_next = RUN;
          stage_next = '0;
          bf_next    = '0;
        end
      end
      RUN: begin
        if (bf_reg == BF_LAST) begin
          state_next = GAP;
        end else begin
          bf_next = bf_reg + 1'b1;
        end
      end
      GAP: begin
        bf_next = '0;
        if (stage_reg == STAGE_LAST) begin
          state_next = DONE;
          stage_next = '0;
        end else begin
          state_next = RUN;
          stage_next = stage_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
        stage_next = '0;
        bf_next    = '0;
      end
      default: begin
        state_next = IDLE;
        stage_next = '0;
        bf_next    = '0;
      end
    endcase
  end

  // Per-stage address candidates use constant shifts, so no barrel shifter
  // is needed; the active stage then selects one set.
  logic [LOG2_N-1:0] bf_ext;
  logic [LOG2_N-1:0] a_cand  [LOG2_N];
  logic [LOG2_N-1:0] b_cand  [LOG2_N];
  logic [BFW-1:0]    tw_cand [LOG2_N];

  assign bf_ext = {1'b0, bf_next};

  generate
    for (genvar gi = 0; gi < LOG2_N; gi++) begin : g_stage
      localparam logic [LOG2_N-1:0] HALF = LOG2_N'(1 << gi);
      logic [LOG2_N-1:0] low;
      assign low         = bf_ext & (HALF - 1'b1);
      assign a_cand[gi]  = ((bf_ext >> gi) << (gi + 1)) | low;
      assign b_cand[gi]  = a_cand[gi] | HALF;
      assign tw_cand[gi] = low[BFW-1:0] << (BFW - gi);
    end
  endgenerate

  logic [LOG2_N-1:0] a_sel, b_sel;
  logic [BFW-1:0]    tw_sel;

  // Pick the address set belonging to the stage that will be read next cycle.
  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    tw_sel = '0;
    for (int i = 0; i < LOG2_N; i++) begin
      if (stage_next == LOG2_N'(i)) begin
        a_sel  = a_cand[i];
        b_sel  = b_cand[i];
        tw_sel = tw_cand[i];
      end
    end
  end

  logic run_next;
  assign run_next = (state_next == RUN);

  // State, counters and every output are registered; the write leg is the
  // read leg delayed one cycle to match the RAM read latency.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      stage_reg   <= '0;
      bf_reg      <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_stage     <= '0;
      o_rd_en     <= 1'b0;
      o_rd_addr_A <= '0;
      o_rd_addr_B <= '0;
      o_tw_addr   <= '0;
      o_wr_en     <= 1'b0;
      o_wr_addr_A <= '0;
      o_wr_addr_B <= '0;
    end else begin
      state_reg   <= state_next;
      stage_reg   <= stage_next;
      bf_reg      <= bf_next;
      o_busy      <= run_next || (state_next == GAP);
      o_done      <= (state_next == DONE);
      o_stage     <= stage_next;
      o_rd_en     <= run_next;
      o_rd_addr_A <= run_next ? a_sel : '0;
      o_rd_addr_B <= run_next ? b_sel : '0;
      o_tw_addr   <= run_next ? tw_sel : '0;
      o_wr_en     <= o_rd_en;
      o_wr_addr_A <= o_rd_addr_A;
      o_wr_addr_B <= o_rd_addr_B;
    end
  end

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Testbench for fft_stage_ctrl (LOG2_N=4): a schedule-level reference model
// checked every cycle, directed timing/address checks, a RAM + butterfly +
// twiddle ROM datapath for an impulse transform, and randomized start/reset.
module tb_fft_stage_ctrl;
  localparam int L      = 4;
  localparam int N      = 16;
  localparam int HALF_N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         o_busy, o_done, o_rd_en, o_wr_en;
  logic [L-1:0] o_stage, o_rd_addr_A, o_rd_addr_B, o_wr_addr_A, o_wr_addr_B;
  logic [L-2:0] o_tw_addr;

  always #5 clk = ~clk;

  fft_stage_ctrl #(.LOG2_N(L)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_busy(o_busy), .o_done(o_done), .o_stage(o_stage),
    .o_rd_en(o_rd_en), .o_rd_addr_A(o_rd_addr_A), .o_rd_addr_B(o_rd_addr_B),
    .o_tw_addr(o_tw_addr), .o_wr_en(o_wr_en),
    .o_wr_addr_A(o_wr_addr_A), .o_wr_addr_B(o_wr_addr_B)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model: per-cycle expected outputs ----------
  typedef struct {
    int busy; int done; int stage; int rd_en; int ra; int rb; int tw;
    int wr_en; int wa; int wb;
  } exp_t;

  exp_t cur;
  exp_t nxt;
  exp_t sched[$];

  function automatic exp_t blank();
    exp_t e;
    e.busy = 0; e.done = 0; e.stage = 0; e.rd_en = 0; e.ra = 0; e.rb = 0;
    e.tw = 0; e.wr_en = 0; e.wa = 0; e.wb = 0;
    return e;
  endfunction

  // Whole transform as a list of cycles: N/2 butterflies + one gap per stage, then DONE.
  task automatic build_schedule();
    exp_t e;
    for (int s = 0; s < L; s++) begin
      int half;
      half = 1 << s;
      for (int bf = 0; bf < HALF_N; bf++) begin
        e = blank();
        e.busy = 1; e.stage = s; e.rd_en = 1;
        e.ra = ((bf >> s) << (s + 1)) | (bf & (half - 1));
        e.rb = e.ra | half;
        e.tw = (bf & (half - 1)) << (L - 1 - s);
        sched.push_back(e);
      end
      e = blank();
      e.busy = 1; e.stage = s;
      sched.push_back(e);
    end
    e = blank();
    e.done = 1;
    sched.push_back(e);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sched.delete();
      cur = blank();
    end else begin
      if (sched.size() > 0) nxt = sched.pop_front();
      else if (cur.done == 0 && start == 1'b1) begin
        build_schedule();
        nxt = sched.pop_front();
      end else nxt = blank();
      nxt.wr_en = cur.rd_en;
      nxt.wa    = cur.ra;
      nxt.wb    = cur.rb;
      cur = nxt;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("busy", o_busy, cur.busy);
    chk("done", o_done, cur.done);
    chk("stage", o_stage, cur.stage);
    chk("rd_en", o_rd_en, cur.rd_en);
    chk("rd_addr_A", o_rd_addr_A, cur.ra);
    chk("rd_addr_B", o_rd_addr_B, cur.rb);
    chk("tw_addr", o_tw_addr, cur.tw);
    chk("wr_en", o_wr_en, cur.wr_en);
    chk("wr_addr_A", o_wr_addr_A, cur.wa);
    chk("wr_addr_B", o_wr_addr_B, cur.wb);
    if (o_rd_en && o_wr_en)
      chk("raw_hazard",
          int'(o_rd_addr_A == o_wr_addr_A || o_rd_addr_A == o_wr_addr_B ||
               o_rd_addr_B == o_wr_addr_A || o_rd_addr_B == o_wr_addr_B), 0);
  end

  // ---------------- datapath model: RAM, twiddle ROM, butterfly ---------
  int   ram_re [N];
  int   ram_im [N];
  int   rom_re [HALF_N];
  int   rom_im [HALF_N];
  int   rd_are, rd_aim, rd_bre, rd_bim, twr, twi, t_re, t_im;
  logic load_impulse = 1'b0;

  initial begin
    for (int k = 0; k < HALF_N; k++) begin
      rom_re[k] = int'(16384.0 * $cos(2.0 * 3.14159265358979 * k / N));
      rom_im[k] = -int'(16384.0 * $sin(2.0 * 3.14159265358979 * k / N));
    end
  end

  always @(posedge clk) begin
    if (load_impulse) begin
      for (int i = 0; i < N; i++) begin
        ram_re[i] <= (i == 0) ? (1 << 6) : 0;
        ram_im[i] <= 0;
      end
    end else begin
      if (o_wr_en) begin
        t_re = (rd_bre * twr - rd_bim * twi) >>> 14;
        t_im = (rd_bre * twi + rd_bim * twr) >>> 14;
        ram_re[o_wr_addr_A] <= rd_are + t_re;
        ram_im[o_wr_addr_A] <= rd_aim + t_im;
        ram_re[o_wr_addr_B] <= rd_are - t_re;
        ram_im[o_wr_addr_B] <= rd_aim - t_im;
      end
      if (o_rd_en) begin
        rd_are <= ram_re[o_rd_addr_A];
        rd_aim <= ram_im[o_rd_addr_A];
        rd_bre <= ram_re[o_rd_addr_B];
        rd_bim <= ram_im[o_rd_addr_B];
        twr    <= rom_re[o_tw_addr];
        twi    <= rom_im[o_tw_addr];
      end
    end
  end

  // ---------------- directed measurement helpers ----------------
  int nbusy, busy_first, busy_last, nrd, nwr;
  int done_q[$];
  int log_a [64];
  int log_b [64];
  int log_t [64];

  task automatic wait_idle();
    int n;
    n = 0;
    while ((o_busy || o_done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(o_busy || o_done), 0);
    @(negedge clk);
  endtask

  // mode 0: single pulse; 1: re-pulse at cycles 5 and 37; 2: held high to cycle 70
  task automatic measure(input int mode, input int ncyc);
    nbusy = 0; busy_first = -1; busy_last = -1; nrd = 0; nwr = 0;
    done_q.delete();
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (o_busy) begin
        nbusy++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (o_done) done_q.push_back(c);
      if (o_rd_en) begin
        if (nrd < 64) begin
          log_a[nrd] = int'(o_rd_addr_A);
          log_b[nrd] = int'(o_rd_addr_B);
          log_t[nrd] = int'(o_tw_addr);
        end
        nrd++;
      end
      if (o_wr_en) nwr++;
      case (mode)
        1:       start = (c == 5 || c == 37);
        2:       start = (c < 70);
        default: start = 1'b0;
      endcase
    end
    start = 1'b0;
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_wr_en"}, o_wr_en, 0);
    chk({tag, "_rd_en"}, o_rd_en, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_stage"}, o_stage, 0);
    chk({tag, "_addr"}, int'(o_rd_addr_A) + int'(o_rd_addr_B) + int'(o_wr_addr_A) +
        int'(o_wr_addr_B) + int'(o_tw_addr), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_wr_en", o_wr_en, 0);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of stage 2.
    begin
      int n;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      n = 0;
      while (!(o_stage == 2 && o_rd_en) && n < 60) begin
        @(negedge clk);
        n++;
      end
      chk("reach_stage2", int'(o_stage == 2 && o_rd_en), 1);
      @(negedge clk);
      async_reset_check("midrun_reset");
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      chk("no_done_after_abort", o_done, 0);
    end

    // Full transform on an impulse; timing, counts and literal addresses.
    @(negedge clk) load_impulse = 1'b1;
    @(negedge clk) load_impulse = 1'b0;
    measure(0, 40);
    $display("run pulse: busy %0d cycles, reads %0d, writes %0d", nbusy, nrd, nwr);
    chk("busy_cycles", nbusy, 36);
    chk("busy_first", busy_first, 1);
    chk("busy_last", busy_last, 36);
    chk("done_count", done_q.size(), 1);
    if (done_q.size() > 0) chk("done_cycle", done_q[0], 37);
    chk("rd_pulses", nrd, 32);
    chk("wr_pulses", nwr, 32);
    for (int bf = 0; bf < 8; bf++) begin
      chk("s0_A", log_a[bf], 2 * bf);
      chk("s0_B", log_b[bf], 2 * bf + 1);
      chk("s0_tw", log_t[bf], 0);
      chk("s3_A", log_a[24 + bf], bf);
      chk("s3_B", log_b[24 + bf], bf + 8);
      chk("s3_tw", log_t[24 + bf], bf);
    end
    chk("s1_bf0_A", log_a[8], 0);  chk("s1_bf0_B", log_b[8], 2);  chk("s1_bf0_tw", log_t[8], 0);
    chk("s1_bf1_A", log_a[9], 1);  chk("s1_bf1_B", log_b[9], 3);  chk("s1_bf1_tw", log_t[9], 4);
    chk("s1_bf2_A", log_a[10], 4); chk("s1_bf2_B", log_b[10], 6); chk("s1_bf2_tw", log_t[10], 0);
    for (int i = 0; i < N; i++) begin
      chk("fft_re", ram_re[i], 64);
      chk("fft_im", ram_im[i], 0);
    end
    wait_idle();

    // Re-pulsed start while busy and in DONE is ignored.
    measure(1, 76);
    $display("run repulse: done pulses %0d", done_q.size());
    chk("repulse_done_count", done_q.size(), 1);
    if (done_q.size() > 0) chk("repulse_done_cycle", done_q[0], 37);
    chk("repulse_busy", nbusy, 36);
    wait_idle();

    // Start held high: back-to-back runs.
    measure(2, 80);
    $display("run held: done pulses %0d", done_q.size());
    chk("held_done_count", done_q.size(), 2);
    if (done_q.size() > 1) begin
      chk("held_done0", done_q[0], 37);
      chk("held_done1", done_q[1], 75);
    end
    chk("held_rd_pulses", nrd, 64);
    wait_idle();

    // Randomized start traffic with occasional asynchronous resets.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      start = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 199) == 0) begin
        async_reset_check("rand_reset");
        @(negedge clk) rst = 1'b0;
      end
    end
    start = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
